// File: rtl/piso_tx_if.sv
// piso_tx_if: word-in / bit-out bundle for piso_tx.
//   din, din_valid   upstream -> transmitter, parallel word + valid
//   din_ready        transmitter -> upstream, word can be taken this cycle
//   dout, dout_valid serial bit (MSB first) + qualifier
//   dout_first, done bit is the MSB / LSB of its word
// master: the side that supplies words and watches the serial stream.
// slave:  the transmitter itself.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_first;
    logic             done;

    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_valid, dout_first, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_valid, dout_first, done
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter, MSB first.
// A one-word holding register lets the next word be taken while the current
// one is still shifting, so held-valid upstream gets gapless output.
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    piso_tx_if.slave (din/din_valid/din_ready in, serial stream out)
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    piso_tx_if.slave   bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             xfer;

    // Ready depends only on reset and the hold flag, never on din_valid.
    assign bus.din_ready = reset && !hold_full;
    assign xfer          = bus.din_valid && bus.din_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sreg      <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sreg  <= bus.din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        sreg <= {sreg[WIDTH-2:0], 1'b0};
                        cnt  <= cnt + 1'b1;
                        if (xfer) begin
                            hold      <= bus.din;
                            hold_full <= 1'b1;
                        end
                    end else begin
                        // LSB cycle: the held word has priority; ready is low
                        // while hold_full, so a direct accept cannot collide.
                        cnt <= '0;
                        if (hold_full) begin
                            sreg      <= hold;
                            hold_full <= 1'b0;
                        end else if (xfer) begin
                            sreg <= bus.din;
                        end else begin
                            sreg  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout_valid = (state == SHIFT);
    assign bus.dout       = bus.dout_valid & sreg[WIDTH-1];
    assign bus.dout_first = bus.dout_valid && (cnt == '0);
    assign bus.done       = bus.dout_valid && (cnt == LAST);
endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W)) bus ();
    piso_tx #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Receiver stand-in: 4-bit shift register fed from dout every edge.
    logic [W-1:0] sipo_q;
    always_ff @(posedge clk) sipo_q <= {sipo_q[W-2:0], bus.dout};

    // Reference model: an ordered stream of bits still to appear on dout.
    typedef struct packed {
        logic         b;
        logic         first;
        logic         last;
        logic [W-1:0] word;
    } ent_t;

    ent_t         mq[$];
    logic [W-1:0] src[$];   // words upstream wants to send, in order
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input logic [W-1:0] obs, input logic [W-1:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic         xfer, rs, had;
        logic [W-1:0] w;
        ent_t         cur;
        // upstream holds din stable while valid until it is consumed
        bus.din_valid = (src.size() > 0);
        if (src.size() > 0) bus.din = src[0];
        rs   = reset;
        w    = bus.din;
        // a word is accepted when at most one word (<= W bits) is outstanding
        xfer = rs && bus.din_valid && (mq.size() <= W);
        had  = (mq.size() > 0);
        cur  = '0;
        if (had) cur = mq[0];
        @(posedge clk);
        if (!rs) begin
            mq.delete();
        end else begin
            if (had) void'(mq.pop_front());
            if (xfer) begin
                void'(src.pop_front());
                for (int i = W - 1; i >= 0; i--)
                    mq.push_back('{w[i], (i == W - 1), (i == 0), w});
            end
        end
        #1;
        if (had && cur.last) chk(sipo_q, cur.word, "sipo_q");
        if (mq.size() > 0) begin
            chk(W'(bus.dout_valid), W'(1'b1), "dout_valid");
            chk(W'(bus.dout), W'(mq[0].b), "dout");
            chk(W'(bus.dout_first), W'(mq[0].first), "dout_first");
            chk(W'(bus.done), W'(mq[0].last), "done");
        end else begin
            chk(W'(bus.dout_valid), '0, "dout_valid");
            chk(W'(bus.dout), '0, "dout");
            chk(W'(bus.dout_first), '0, "dout_first");
            chk(W'(bus.done), '0, "done");
        end
        chk(W'(bus.din_ready), W'(reset && (mq.size() <= W)), "din_ready");
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() > 0 || src.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        if (mq.size() > 0 || src.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout observed=%0d expected=0", mq.size() + src.size());
        end
        tick();
    endtask

    initial begin
        int n;
        reset         = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;

        // Reset held with a word offered: nothing moves, ready stays low.
        src.push_back(4'hF);
        repeat (3) tick();
        reset = 1'b1;
        drain();

        // Single word.
        src.push_back(4'b1011);
        drain();
        repeat (2) tick();

        // Back-to-back with valid held: 1010 0101 1100 contiguous.
        src.push_back(4'hA);
        src.push_back(4'h5);
        src.push_back(4'hC);
        drain();

        // LSB-cycle accept: next word offered only in the done cycle.
        src.push_back(4'hE);
        tick();
        n = 0;
        while (mq.size() != 1 && n < 10) begin
            tick();
            n++;
        end
        if (mq.size() != 1) begin
            errors++;
            $display("FAIL lsb_wait observed=%0d expected=1", mq.size());
        end
        src.push_back(4'h6);
        drain();

        // Reset during bit 2 of 4'h9 with 4'h3 held: both lost.
        src.push_back(4'h9);
        src.push_back(4'h3);
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (6) tick();

        // Loopback through the receiver stand-in.
        src.push_back(4'h3);
        src.push_back(4'hC);
        drain();

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            if (src.size() == 0 && $urandom_range(0, 2) != 0)
                src.push_back(W'($urandom));
            reset = ($urandom_range(0, 59) != 0);
            tick();
        end
        reset = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
